csa_resolver: RTL

- Consumer end of the carry-save interface. Accepts a redundant (sum vector, carry vector) pair from a carry-save compression stage and resolves it to a single binary result.
- Carry propagation is split into CHUNK-bit slices, one slice per clock. Wide operands therefore resolve without a full-width ripple path.
- Valid/ready handshake on both input and output, so it can sit between a CSA tree and a downstream register or accumulator.

---
 rtl/csa_resolver.sv | 100 ++++++++++
 1 files changed

// File: rtl/csa_resolver.sv
// Resolves a redundant (sum, carry) vector pair into one binary result,
// propagating the carry through one CHUNK-bit slice per clock.
module csa_resolver #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] s_vec,
  input  logic [WIDTH-1:0] c_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] s_reg;
  logic [WIDTH-1:0] c_reg;
  logic             carry_reg;
  logic [IW-1:0]    idx_reg;
  logic [WIDTH:0]   result_reg;
  logic             out_valid_reg;

  logic [CHUNK-1:0] s_slice [NCHUNK];
  logic [CHUNK-1:0] c_slice [NCHUNK];
  logic [CHUNK:0]   slice_sum;

  // Split the latched operands into slices so the adder only ever sees CHUNK bits.
  generate
    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
      assign s_slice[gi] = s_reg[gi*CHUNK +: CHUNK];
      assign c_slice[gi] = c_reg[gi*CHUNK +: CHUNK];
    end
  endgenerate

  assign slice_sum = {1'b0, s_slice[idx_reg]} + {1'b0, c_slice[idx_reg]}
                   + {{CHUNK{1'b0}}, carry_reg};

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == BUSY);
  assign out_valid = out_valid_reg;
  assign result    = result_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      s_reg         <= '0;
      c_reg         <= '0;
      carry_reg     <= 1'b0;
      idx_reg       <= '0;
      result_reg    <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            s_reg     <= s_vec;
            c_reg     <= c_vec;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          result_reg[idx_reg*CHUNK +: CHUNK] <= slice_sum[CHUNK-1:0];
          carry_reg <= slice_sum[CHUNK];
          idx_reg   <= idx_reg + IW'(1);
          if (idx_reg == LAST_IDX) begin
            result_reg[WIDTH] <= slice_sum[CHUNK];
            out_valid_reg     <= 1'b1;
            state_reg         <= DONE;
          end
        end
        DONE: begin
          // result is deliberately left intact after the handshake
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

endmodule
